// File: rtl/bcd_arb_pkg.sv
// Shared types, constants and the round-robin pick helper for the BCD-to-binary arbiter.
package bcd_arb_pkg;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    DONE
  } arb_state_e;

  // Converter internal states.
  typedef enum logic [1:0] {
    CV_IDLE,
    CV_CALC,
    CV_DONE
  } conv_state_e;

  localparam logic [3:0] BCD_MAX = 4'd9;
  localparam int         MAX_REQ = 8;

  // First set bit of pending, searching upward from rr_ptr and wrapping at n_req.
  // Returns rr_ptr when nothing is pending; callers qualify with |pending.
  function automatic logic [2:0] rr_pick(input logic [7:0] pending,
                                         input logic [2:0] rr_ptr,
                                         input int         n_req);
    int idx;
    rr_pick = rr_ptr;
    // Walk from the farthest offset down so the nearest candidate wins last.
    for (int i = MAX_REQ - 1; i >= 0; i--) begin
      if (i < n_req) begin
        idx = int'(rr_ptr) + i;
        if (idx >= n_req) idx = idx - n_req;
        if (pending[idx[2:0]]) rr_pick = idx[2:0];
      end
    end
  endfunction

endpackage

// File: rtl/bcd2bin.sv
// Two-digit BCD to binary converter. Accepts a start pulse while ready, then
// accumulates tens by repeated addition; done_tick pulses for one cycle with bin valid.
module bcd2bin
  import bcd_arb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [3:0] dig1,
  input  logic [3:0] dig0,
  output logic [6:0] bin,
  output logic       ready,
  output logic       done_tick
);

  conv_state_e state_q;
  logic [6:0]  acc_q;
  logic [3:0]  tens_q;

  // Conversion sequencer: load units, add ten per remaining tens digit, then signal done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CV_IDLE;
      acc_q   <= '0;
      tens_q  <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      case (state_q)
        CV_IDLE: begin
          if (start) begin
            acc_q   <= 7'(dig0);
            tens_q  <= dig1;
            state_q <= CV_CALC;
          end
        end
        CV_CALC: begin
          if (tens_q == 4'd0) begin
            state_q <= CV_DONE;
          end else begin
            acc_q  <= acc_q + 7'd10;
            tens_q <= tens_q - 4'd1;
          end
        end
        CV_DONE: state_q <= CV_IDLE;
        default: state_q <= CV_IDLE;
      endcase
    end
  end

  assign bin       = acc_q;
  assign ready     = (state_q == CV_IDLE);
  assign done_tick = (state_q == CV_DONE);

endmodule

// File: rtl/bcd2bin_arbiter.sv
// Round-robin arbiter sharing one bcd2bin converter among N_REQ requesters.
// Each request pulse is buffered in a per-requester slot; granted slots are
// converted and returned tagged with the requester id.
module bcd2bin_arbiter
  import bcd_arb_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N_REQ-1:0]     req,
  input  logic [4*N_REQ-1:0]   req_dig1,
  input  logic [4*N_REQ-1:0]   req_dig0,
  output logic [N_REQ-1:0]     pending,
  output logic [6:0]           result,
  output logic [ID_W-1:0]      result_id,
  output logic                 result_valid,
  output logic                 result_err,
  output logic                 overrun,
  output logic                 busy
);

  arb_state_e        state_q;
  logic [ID_W-1:0]   rr_ptr_q;
  logic [ID_W-1:0]   gnt_q;
  logic [N_REQ-1:0]  pending_q;
  logic [3:0]        slot_dig1_q [N_REQ];
  logic [3:0]        slot_dig0_q [N_REQ];
  logic [3:0]        lat_dig1_q;
  logic [3:0]        lat_dig0_q;
  logic              start_q;
  logic [6:0]        result_q;
  logic [ID_W-1:0]   result_id_q;
  logic              valid_q;
  logic              err_q;
  logic              overrun_q;

  logic              grant_en;
  logic [ID_W-1:0]   grant_id;
  logic [N_REQ-1:0]  grant_mask;
  logic [N_REQ-1:0]  accept;
  logic [N_REQ-1:0]  drop;
  logic [3:0]        g_dig1;
  logic [3:0]        g_dig0;
  logic              g_bad;

  logic [6:0]        conv_bin;
  logic              conv_ready;
  logic              conv_done;

  // Grant selection and request acceptance for the current cycle.
  always_comb begin
    // NOTE: every signal gets a default before any branch so no latch is inferred.
    grant_id   = ID_W'(rr_pick(8'(pending_q), 3'(rr_ptr_q), N_REQ));
    grant_en   = (state_q == IDLE) && (|pending_q) && conv_ready;
    grant_mask = '0;
    if (grant_en) grant_mask = N_REQ'(1) << grant_id;
    g_dig1 = slot_dig1_q[grant_id];
    g_dig0 = slot_dig0_q[grant_id];
    g_bad  = (g_dig1 > BCD_MAX) || (g_dig0 > BCD_MAX);
    // A request is dropped only if its slot stays occupied past this edge;
    // a slot being granted this cycle frees up for the incoming request.
    drop   = req & pending_q & ~grant_mask;
    accept = req & ~drop;
  end

  // Slot storage: digits written when a request is accepted.
  always_ff @(posedge clk) begin
    // NOTE: slots carry no reset; pending gates their use, so stale contents are never read.
    for (int i = 0; i < N_REQ; i++) begin
      if (accept[i]) begin
        slot_dig1_q[i] <= req_dig1[4*i +: 4];
        slot_dig0_q[i] <= req_dig0[4*i +: 4];
      end
    end
  end

  // Pending bookkeeping, overrun flag and the grant/issue/wait/done sequencer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gnt_q       <= '0;
      pending_q   <= '0;
      lat_dig1_q  <= '0;
      lat_dig0_q  <= '0;
      start_q     <= 1'b0;
      result_q    <= '0;
      result_id_q <= '0;
      valid_q     <= 1'b0;
      err_q       <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      pending_q <= (pending_q & ~grant_mask) | accept;
      overrun_q <= |drop;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      start_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (grant_en) begin
            gnt_q      <= grant_id;
            lat_dig1_q <= g_dig1;
            lat_dig0_q <= g_dig0;
            if (g_bad) begin
              // Invalid digits never reach the converter.
              result_q    <= '0;
              result_id_q <= grant_id;
              err_q       <= 1'b1;
              valid_q     <= 1'b1;
              state_q     <= DONE;
            end else begin
              start_q <= 1'b1;
              state_q <= ISSUE;
            end
          end
        end
        ISSUE: state_q <= WAIT;
        WAIT: begin
          if (conv_done) begin
            result_q    <= conv_bin;
            result_id_q <= gnt_q;
            valid_q     <= 1'b1;
            state_q     <= DONE;
          end
        end
        DONE: begin
          rr_ptr_q <= (gnt_q == ID_W'(N_REQ - 1)) ? '0 : gnt_q + 1'b1;
          state_q  <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  bcd2bin u_conv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start_q),
    .dig1      (lat_dig1_q),
    .dig0      (lat_dig0_q),
    .bin       (conv_bin),
    .ready     (conv_ready),
    .done_tick (conv_done)
  );

  assign pending      = pending_q;
  assign result       = result_q;
  assign result_id    = result_id_q;
  assign result_valid = valid_q;
  assign result_err   = err_q;
  assign overrun      = overrun_q;
  assign busy         = (state_q != IDLE);

endmodule

// File: tb/tb_bcd2bin_arbiter.sv
// Self-checking bench for bcd2bin_arbiter: directed scenarios, a full digit sweep per
// requester and random batches, all compared against a round-robin reference model.
module tb_bcd2bin_arbiter;

  localparam int N = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [N-1:0]    req = '0;
  logic [4*N-1:0]  req_dig1 = '0;
  logic [4*N-1:0]  req_dig0 = '0;
  logic [N-1:0]    pending;
  logic [6:0]      result;
  logic [1:0]      result_id;
  logic            result_valid;
  logic            result_err;
  logic            overrun;
  logic            busy;

  typedef struct {
    int id;
    int val;
    int err;
    int pend;
  } res_t;

  res_t got_q[$];
  res_t exp_q[$];
  int   checks      = 0;
  int   failures    = 0;
  int   overrun_cnt = 0;
  int   start_cnt   = 0;
  int   model_rr    = 0;

  always #5 clk = ~clk;

  bcd2bin_arbiter #(.N_REQ(N), .ID_W(2)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .req_dig1     (req_dig1),
    .req_dig0     (req_dig0),
    .pending      (pending),
    .result       (result),
    .result_id    (result_id),
    .result_valid (result_valid),
    .result_err   (result_err),
    .overrun      (overrun),
    .busy         (busy)
  );

  // Monitor: record every result, overrun pulse and converter start.
  always @(negedge clk) begin
    if (rst_n) begin
      if (result_valid)
        got_q.push_back('{int'(result_id), int'(result), int'(result_err), int'(pending)});
      if (overrun) overrun_cnt++;
      if (dut.start_q) start_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Reference: value of a BCD pair and the round-robin pointer after serving id.
  task automatic push_exp(input int id, input int d1, input int d0, input int pend);
    res_t e;
    e.id   = id;
    e.err  = (d1 > 9 || d0 > 9) ? 1 : 0;
    e.val  = e.err ? 0 : d1 * 10 + d0;
    e.pend = pend;
    exp_q.push_back(e);
    model_rr = (id + 1) % N;
  endtask

  // Reference order for a batch captured together while idle: rotate from model_rr.
  task automatic model_batch(input int mask, input int d1[N], input int d0[N]);
    int rem;
    rem = mask;
    while (rem != 0) begin
      int pick;
      pick = -1;
      for (int k = 0; k < N; k++) begin
        int c;
        c = (model_rr + k) % N;
        if (pick < 0 && ((rem >> c) & 1) == 1) pick = c;
      end
      rem = rem & ~(1 << pick);
      push_exp(pick, d1[pick], d0[pick], rem);
    end
  endtask

  task automatic issue(input int mask, input int d1[N], input int d0[N]);
    tick();
    req = 4'(mask);
    for (int i = 0; i < N; i++) begin
      req_dig1[4*i +: 4] = 4'(d1[i]);
      req_dig0[4*i +: 4] = 4'(d0[i]);
    end
    tick();
    req = '0;
  endtask

  task automatic wait_results(input int n);
    for (int c = 0; c < 600 && got_q.size() < n; c++) tick();
    check("result_timeout", (got_q.size() >= n) ? 1 : 0, 1);
  endtask

  task automatic compare(input string tag);
    while (exp_q.size() > 0) begin
      res_t e, g;
      e = exp_q.pop_front();
      if (got_q.size() == 0) begin
        check($sformatf("%s_missing", tag), 0, 1);
      end else begin
        g = got_q.pop_front();
        check($sformatf("%s_id", tag),   g.id,   e.id);
        check($sformatf("%s_val", tag),  g.val,  e.val);
        check($sformatf("%s_err", tag),  g.err,  e.err);
        check($sformatf("%s_pend", tag), g.pend, e.pend);
      end
    end
    check($sformatf("%s_extra", tag), got_q.size(), 0);
    got_q.delete();
  endtask

  task automatic reset_dut();
    rst_n    = 1'b0;
    req      = '0;
    req_dig1 = '0;
    req_dig0 = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    model_rr = 0;
    got_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int d1[N];
    int d0[N];
    int s;
    int m;

    // Reset state.
    reset_dut();
    check("rst_pending", pending, 0);
    check("rst_result", result, 0);
    check("rst_result_id", result_id, 0);
    check("rst_valid", result_valid, 0);
    check("rst_err", result_err, 0);
    check("rst_overrun", overrun, 0);
    check("rst_busy", busy, 0);

    // 1: single request id2 = 47.
    d1 = '{0, 0, 4, 0};
    d0 = '{0, 0, 7, 0};
    issue(4'b0100, d1, d0);
    check("t1_pending", pending, 4'b0100);
    check("t1_busy_before", busy, 0);
    model_batch(4'b0100, d1, d0);
    wait_results(1);
    check("t1_busy_done", busy, 1);
    tick();
    check("t1_busy_after", busy, 0);
    check("t1_valid_pulse", result_valid, 0);
    check("t1_hold", result, 47);
    compare("t1");

    // 2: four simultaneous requests from rr_ptr=0.
    reset_dut();
    d1 = '{1, 3, 5, 9};
    d0 = '{2, 4, 6, 9};
    issue(4'b1111, d1, d0);
    check("t2_pending", pending, 4'b1111);
    model_batch(4'b1111, d1, d0);
    wait_results(4);
    tick();
    compare("t2");

    // 3: serve id1 (rr_ptr -> 2), then ids 0 and 3 together: 3 before 0.
    d1 = '{0, 2, 0, 0};
    d0 = '{0, 1, 0, 0};
    issue(4'b0010, d1, d0);
    model_batch(4'b0010, d1, d0);
    wait_results(1);
    tick();
    compare("t3a");
    d1 = '{6, 0, 0, 8};
    d0 = '{5, 0, 0, 1};
    issue(4'b1001, d1, d0);
    model_batch(4'b1001, d1, d0);
    wait_results(2);
    tick();
    compare("t3b");

    // 4: invalid tens digit on id1.
    s  = start_cnt;
    d1 = '{0, 10, 0, 0};
    d0 = '{0, 3, 0, 0};
    issue(4'b0010, d1, d0);
    tick();
    check("t4_latency", result_valid, 1);
    model_batch(4'b0010, d1, d0);
    wait_results(1);
    tick();
    compare("t4");
    check("t4_no_start", start_cnt - s, 0);

    // 5: second request on a still-pending id1 is dropped.
    s  = overrun_cnt;
    d1 = '{8, 0, 0, 0};
    d0 = '{8, 0, 0, 0};
    issue(4'b0001, d1, d0);
    d1 = '{0, 2, 0, 0};
    d0 = '{0, 5, 0, 0};
    issue(4'b0010, d1, d0);
    d1 = '{0, 7, 0, 0};
    d0 = '{0, 7, 0, 0};
    issue(4'b0010, d1, d0);
    push_exp(0, 8, 8, 4'b0010);
    push_exp(1, 2, 5, 0);
    wait_results(2);
    tick();
    compare("t5");
    check("t5_overrun", overrun_cnt - s, 1);

    // 6: reset while waiting on the converter.
    s  = start_cnt;
    d1 = '{0, 0, 9, 0};
    d0 = '{0, 0, 9, 0};
    issue(4'b0100, d1, d0);
    for (int c = 0; c < 20 && start_cnt == s; c++) tick();
    check("t6_started", (start_cnt != s) ? 1 : 0, 1);
    tick();
    check("t6_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check("t6_pending", pending, 0);
    check("t6_result", result, 0);
    check("t6_result_id", result_id, 0);
    check("t6_valid", result_valid, 0);
    check("t6_err", result_err, 0);
    check("t6_overrun", overrun, 0);
    check("t6_busy_rst", busy, 0);
    repeat (2) tick();
    rst_n    = 1'b1;
    model_rr = 0;
    got_q.delete();
    repeat (30) tick();
    check("t6_no_result", got_q.size(), 0);
    d1 = '{0, 0, 0, 3};
    d0 = '{0, 0, 0, 3};
    issue(4'b1000, d1, d0);
    model_batch(4'b1000, d1, d0);
    wait_results(1);
    tick();
    compare("t6");

    // Sweep: every requester sees every value 0..99.
    for (int v = 0; v < 100; v++) begin
      for (int i = 0; i < N; i++) begin
        d1[i] = ((v + 25 * i) % 100) / 10;
        d0[i] = ((v + 25 * i) % 100) % 10;
      end
      issue(4'b1111, d1, d0);
      model_batch(4'b1111, d1, d0);
      wait_results(4);
      tick();
      compare("sweep");
    end

    // Random batches, including invalid digits.
    for (int r = 0; r < 40; r++) begin
      m = int'($urandom_range(1, 15));
      for (int i = 0; i < N; i++) begin
        d1[i] = int'($urandom_range(0, 11));
        d0[i] = int'($urandom_range(0, 11));
      end
      issue(m, d1, d0);
      model_batch(m, d1, d0);
      wait_results($countones(4'(m)));
      tick();
      compare("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
